// File: rtl/regfile_wb_arbiter.sv
// Register file write-port arbiter between the WB stage and buffered MDU results,
// with a starvation guard and a per-register pending-MDU scoreboard.
module regfile_wb_arbiter #(
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [4:0]  wb_dst,
    input  logic [31:0] wb_data,
    input  logic        mdu_issue,
    input  logic [4:0]  mdu_issue_dst,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_dst,
    input  logic [31:0] mdu_data,
    output logic        mdu_ready,
    output logic        wb_hold,
    output logic        RegWrite,
    output logic [4:0]  WB_DstReg,
    output logic [31:0] WB_Data,
    output logic [31:0] busy_mask,
    output logic        proto_err
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

    logic [4:0]       fifo_dst  [FIFO_DEPTH];
    logic [31:0]      fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [STV_W-1:0] starve_cnt;

    logic        fifo_empty;
    logic        fifo_full;
    logic        wb_eff;
    logic        fifo_gnt;
    logic        wb_gnt;
    logic        enq;
    logic        issue_eff;
    logic [4:0]  head_dst;
    logic [31:0] head_data;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;

    // Grant and scoreboard decode, all from state at cycle start
    always_comb begin
        fifo_empty = (count == '0);
        fifo_full  = (count == CNT_W'(FIFO_DEPTH));
        head_dst   = fifo_dst[rd_ptr];
        head_data  = fifo_data[rd_ptr];
        wb_eff     = wb_valid && (wb_dst != 5'd0);
        fifo_gnt   = !fifo_empty && (wb_hold || !wb_eff);
        wb_gnt     = wb_eff && !fifo_gnt;
        enq        = mdu_valid && !fifo_full;
        issue_eff  = mdu_issue && (mdu_issue_dst != 5'd0);
        set_mask   = '0;
        clr_mask   = '0;
        if (issue_eff) begin
            set_mask = 32'd1 << mdu_issue_dst;
        end
        if (fifo_gnt && (head_dst != 5'd0)) begin
            clr_mask = 32'd1 << head_dst;
        end
    end

    assign mdu_ready = !fifo_full;

    // Buffer storage needs no reset: validity is tracked by count
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_dst[wr_ptr]  <= mdu_dst;
            fifo_data[wr_ptr] <= mdu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            wb_hold    <= 1'b0;
            RegWrite   <= 1'b0;
            WB_DstReg  <= '0;
            WB_Data    <= '0;
            busy_mask  <= '0;
            proto_err  <= 1'b0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (fifo_gnt) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(enq) - CNT_W'(fifo_gnt);

            // Starvation guard: one-cycle hold after STARVE_LIMIT blocked cycles
            wb_hold <= 1'b0;
            if (fifo_empty || fifo_gnt) begin
                starve_cnt <= '0;
            end else if (starve_cnt == STV_W'(STARVE_LIMIT - 1)) begin
                starve_cnt <= '0;
                wb_hold    <= 1'b1;
            end else begin
                starve_cnt <= starve_cnt + STV_W'(1);
            end

            // A dst=0 head is retired silently and leaves the address/data held
            RegWrite <= 1'b0;
            if (fifo_gnt && (head_dst != 5'd0)) begin
                RegWrite  <= 1'b1;
                WB_DstReg <= head_dst;
                WB_Data   <= head_data;
            end else if (wb_gnt) begin
                RegWrite  <= 1'b1;
                WB_DstReg <= wb_dst;
                WB_Data   <= wb_data;
            end

            busy_mask <= (busy_mask & ~clr_mask) | set_mask;

            if ((wb_hold && wb_valid) || (issue_eff && busy_mask[mdu_issue_dst])) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: expected register-file writes are queued
// by the stimulus and retired by an independent monitor on every RegWrite.
module tb_regfile_wb_arbiter;

    typedef struct packed {
        logic [4:0]  dst;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        reset;
    logic        wb_valid;
    logic [4:0]  wb_dst;
    logic [31:0] wb_data;
    logic        mdu_issue;
    logic [4:0]  mdu_issue_dst;
    logic        mdu_valid;
    logic [4:0]  mdu_dst;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic        wb_hold;
    logic        RegWrite;
    logic [4:0]  WB_DstReg;
    logic [31:0] WB_Data;
    logic [31:0] busy_mask;
    logic        proto_err;

    int n_checks = 0;
    int n_errors = 0;
    wr_t exp_q[$];

    regfile_wb_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .wb_valid     (wb_valid),
        .wb_dst       (wb_dst),
        .wb_data      (wb_data),
        .mdu_issue    (mdu_issue),
        .mdu_issue_dst(mdu_issue_dst),
        .mdu_valid    (mdu_valid),
        .mdu_dst      (mdu_dst),
        .mdu_data     (mdu_data),
        .mdu_ready    (mdu_ready),
        .wb_hold      (wb_hold),
        .RegWrite     (RegWrite),
        .WB_DstReg    (WB_DstReg),
        .WB_Data      (WB_Data),
        .busy_mask    (busy_mask),
        .proto_err    (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] d, input logic [31:0] x);
        wr_t w;
        w.dst  = d;
        w.data = x;
        exp_q.push_back(w);
    endtask

    task automatic set_wb(input logic v, input logic [4:0] d, input logic [31:0] x);
        wb_valid = v;
        wb_dst   = d;
        wb_data  = x;
    endtask

    task automatic set_mdu(input logic v, input logic [4:0] d, input logic [31:0] x);
        mdu_valid = v;
        mdu_dst   = d;
        mdu_data  = x;
    endtask

    task automatic issue(input logic [4:0] d);
        mdu_issue     = 1'b1;
        mdu_issue_dst = d;
        step();
        mdu_issue     = 1'b0;
    endtask

    // Monitor: every write the DUT performs must match the oldest expected write
    always @(negedge clk) begin
        if (RegWrite === 1'b1) begin
            wr_t w;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_write: got dst=%0d data=0x%08h expected none", WB_DstReg, WB_Data);
            end else begin
                w = exp_q.pop_front();
                if (WB_DstReg !== w.dst || WB_Data !== w.data) begin
                    n_errors++;
                    $display("FAIL write: got dst=%0d data=0x%08h expected dst=%0d data=0x%08h",
                             WB_DstReg, WB_Data, w.dst, w.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        set_wb(1'b0, 5'd0, 32'd0);
        set_mdu(1'b0, 5'd0, 32'd0);
        mdu_issue     = 1'b0;
        mdu_issue_dst = 5'd0;
        step();
        step();
        reset = 1'b0;

        // Reset / idle
        check("rst_regwrite", 32'(RegWrite), 32'd0);
        check("rst_dst", 32'(WB_DstReg), 32'd0);
        check("rst_data", WB_Data, 32'd0);
        check("rst_hold", 32'(wb_hold), 32'd0);
        check("rst_busy", busy_mask, 32'd0);
        check("rst_proto", 32'(proto_err), 32'd0);
        check("rst_ready", 32'(mdu_ready), 32'd1);

        // WB only, then a write to r0 which frees the slot
        set_wb(1'b1, 5'd5, 32'hDEAD_BEEF);
        expect_wr(5'd5, 32'hDEAD_BEEF);
        step();
        set_wb(1'b1, 5'd0, 32'h1111_1111);
        step();
        check("wb_r0_regwrite", 32'(RegWrite), 32'd0);
        check("wb_r0_dst_held", 32'(WB_DstReg), 32'd5);
        set_wb(1'b0, 5'd0, 32'd0);

        // MDU on idle pipe: issue, accept at E, write after E+1
        issue(5'd9);
        check("mdu_busy9", busy_mask, 32'h0000_0200);
        set_mdu(1'b1, 5'd9, 32'h0000_1234);
        step();
        set_mdu(1'b0, 5'd0, 32'd0);
        check("mdu_not_yet", 32'(RegWrite), 32'd0);
        expect_wr(5'd9, 32'h0000_1234);
        step();
        check("mdu_busy_clr", busy_mask, 32'd0);

        // Contention: continuous WB to r7 against buffered 3/A and 4/B
        issue(5'd3);
        issue(5'd4);
        set_wb(1'b1, 5'd7, 32'h100);
        set_mdu(1'b1, 5'd3, 32'hA);
        expect_wr(5'd7, 32'h100);
        step();
        set_wb(1'b1, 5'd7, 32'h101);
        set_mdu(1'b1, 5'd4, 32'hB);
        expect_wr(5'd7, 32'h101);
        step();
        check("full_ready", 32'(mdu_ready), 32'd0);
        set_wb(1'b1, 5'd7, 32'h102);
        set_mdu(1'b1, 5'd20, 32'hC);
        expect_wr(5'd7, 32'h102);
        step();
        check("full_ready2", 32'(mdu_ready), 32'd0);
        check("hold_early", 32'(wb_hold), 32'd0);
        set_wb(1'b1, 5'd7, 32'h103);
        expect_wr(5'd7, 32'h103);
        step();
        set_mdu(1'b0, 5'd0, 32'd0);
        set_wb(1'b1, 5'd7, 32'h104);
        expect_wr(5'd7, 32'h104);
        step();
        check("hold_first", 32'(wb_hold), 32'd1);
        set_wb(1'b0, 5'd0, 32'd0);
        expect_wr(5'd3, 32'hA);
        step();
        check("hold_one_cycle", 32'(wb_hold), 32'd0);
        check("ready_after_drain", 32'(mdu_ready), 32'd1);
        check("busy_after_3", busy_mask, 32'h0000_0010);
        for (int i = 0; i < 4; i++) begin
            set_wb(1'b1, 5'd7, 32'h200 + 32'(i));
            expect_wr(5'd7, 32'h200 + 32'(i));
            step();
            check("hold_second", 32'(wb_hold), (i == 3) ? 32'd1 : 32'd0);
        end
        // WB kept valid during hold: dropped, FIFO wins, protocol error
        set_wb(1'b1, 5'd7, 32'h2FF);
        expect_wr(5'd4, 32'hB);
        step();
        set_wb(1'b0, 5'd0, 32'd0);
        check("viol_hold_proto", 32'(proto_err), 32'd1);
        check("busy_after_4", busy_mask, 32'd0);
        step();
        step();
        check("proto_sticky", 32'(proto_err), 32'd1);

        reset = 1'b1;
        step();
        reset = 1'b0;
        check("proto_cleared", 32'(proto_err), 32'd0);

        // Issue to an already-busy register
        issue(5'd6);
        check("proto_before_dup", 32'(proto_err), 32'd0);
        issue(5'd6);
        check("dup_proto", 32'(proto_err), 32'd1);
        check("dup_busy", busy_mask, 32'h0000_0040);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_busy_clr", busy_mask, 32'd0);

        // Same-cycle issue and retire of r12: set wins
        issue(5'd12);
        set_mdu(1'b1, 5'd12, 32'h12);
        step();
        set_mdu(1'b0, 5'd0, 32'd0);
        expect_wr(5'd12, 32'h12);
        issue(5'd12);
        check("same_cycle_busy", busy_mask, 32'h0000_1000);

        // MDU result to r0 retires without a write
        set_mdu(1'b1, 5'd0, 32'h55);
        step();
        set_mdu(1'b0, 5'd0, 32'd0);
        step();
        check("r0_mdu_regwrite", 32'(RegWrite), 32'd0);
        check("r0_mdu_dst_held", 32'(WB_DstReg), 32'd12);

        // Reset mid-operation discards a buffered result
        reset = 1'b1;
        step();
        reset = 1'b0;
        issue(5'd8);
        set_wb(1'b1, 5'd7, 32'h300);
        set_mdu(1'b1, 5'd8, 32'h88);
        expect_wr(5'd7, 32'h300);
        step();
        set_wb(1'b0, 5'd0, 32'd0);
        set_mdu(1'b0, 5'd0, 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("discard_busy", busy_mask, 32'd0);
        check("discard_ready", 32'(mdu_ready), 32'd1);
        step();
        step();
        check("discard_nowrite", 32'(RegWrite), 32'd0);

        step();
        check("drain_queue", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
